axis_bit_gen: RTL and testbench

AXI-stream bit-code generator: the transmit-side counterpart of the bit correlator. On each accepted command it emits one stored ±1 code, modulated to signed samples of ±AMPLITUDE, on all enabled parallel lanes, repeated a given number of times with optional zero-gap beats. It drives DAC or loopback paths and serves as the stimulus source for correlator bring-up. It uses the same CORRELATORS code table as the correlator, so a generated code correlates to a full-scale peak.

---
 rtl/axis_bit_gen_pkg.sv | 23 ++
 rtl/axis_bit_gen.sv | 191 +++++++++++++++++++
 tb/tb_axis_bit_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_bit_gen_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : axis_bit_gen_pkg
// Brief   : Shared types and width helpers for the AXI-stream bit-code
//           generator.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package axis_bit_gen_pkg;

   // Generator sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CODE = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Bits needed to hold 0..n-1, never less than one
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_bit_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : axis_bit_gen
// Brief   : AXI-stream bit-code generator. Each command emits a stored +/-1
//           code as +/-AMPLITUDE samples on the enabled lanes, repeated with
//           optional zero-gap beats after every repetition.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module axis_bit_gen
   import axis_bit_gen_pkg::*;
#(
   parameter int NUM_PARALLEL = 8,
   parameter int WAVE_WIDTH   = 6,
   parameter int AMPLITUDE    = (1 << (WAVE_WIDTH - 1)) - 1,
   parameter int NUM_CORRS    = 1,
   parameter int CORR_LENGTH  = 1,
   parameter logic [NUM_CORRS*CORR_LENGTH-1:0] CORRELATORS = '0,
   parameter int GAP_BEATS    = 0,
   parameter int REPEAT_WIDTH = 8,
   localparam int CW          = clog2_min1(NUM_CORRS),
   localparam int CMD_WIDTH   = NUM_PARALLEL + CW + REPEAT_WIDTH
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic [CMD_WIDTH-1:0]             s_axis_tdata,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [WAVE_WIDTH*NUM_PARALLEL-1:0] m_axis_tdata,
   output logic                             m_axis_tlast,
   output logic [NUM_CORRS-1:0]             m_axis_tdest
);

   localparam int CHW = clog2_min1(CORR_LENGTH);
   localparam int GW  = clog2_min1(GAP_BEATS);
   localparam logic [CHW-1:0]        C_CHIP_LAST = CHW'(CORR_LENGTH - 1);
   localparam logic [GW-1:0]         C_GAP_LAST  = GW'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);
   localparam logic [CW:0]           C_NUM_CODES = (CW + 1)'(NUM_CORRS);
   localparam logic [WAVE_WIDTH-1:0] C_POS       = WAVE_WIDTH'(AMPLITUDE);
   localparam logic [WAVE_WIDTH-1:0] C_NEG       = WAVE_WIDTH'(-AMPLITUDE);

   state_t                          r_state, w_nxt_state;
   logic [NUM_PARALLEL-1:0]         r_mask, w_cmd_mask, w_cur_mask;
   logic [CW-1:0]                   r_idx, w_cmd_idx, w_cur_idx;
   logic [REPEAT_WIDTH-1:0]         r_rpt, w_cmd_rpt, w_cur_rpt;
   logic [REPEAT_WIDTH-1:0]         r_rep, w_cur_rep, w_nxt_rep;
   logic [CHW-1:0]                  r_chip, w_cur_chip, w_nxt_chip;
   logic [GW-1:0]                   r_gap, w_cur_gap, w_nxt_gap;
   logic                            w_in_gap, w_fire, w_adv, w_accept, w_idx_ok;
   logic                            w_rep_more, w_beat_last, w_chip_bit;
   logic [(1<<CHW)-1:0]             w_code;
   logic [WAVE_WIDTH-1:0]           w_sample;
   logic [WAVE_WIDTH*NUM_PARALLEL-1:0] w_beat_data;
   logic                            r_valid, r_last;
   logic [WAVE_WIDTH*NUM_PARALLEL-1:0] r_data;
   logic [NUM_CORRS-1:0]            r_dest;

   // A new command is only taken once the final beat has left the output register
   assign s_axis_tready = ~rst & (r_state == ST_IDLE) & ~r_valid;
   assign w_accept      = s_axis_tvalid & s_axis_tready;
   assign w_adv         = ~r_valid | m_axis_tready;

   assign w_cmd_mask = s_axis_tdata[NUM_PARALLEL-1:0];
   assign w_cmd_idx  = s_axis_tdata[NUM_PARALLEL +: CW];
   assign w_cmd_rpt  = s_axis_tdata[NUM_PARALLEL + CW +: REPEAT_WIDTH];
   assign w_idx_ok   = ({1'b0, w_cmd_idx} < C_NUM_CODES);

   // Position of the beat being produced; in IDLE the first beat comes straight from the command
   always_comb begin
      w_cur_mask = r_mask;
      w_cur_idx  = r_idx;
      w_cur_rpt  = r_rpt;
      w_cur_rep  = r_rep;
      w_cur_chip = r_chip;
      w_cur_gap  = r_gap;
      w_in_gap   = (r_state == ST_GAP);
      w_fire     = w_adv;
      if (r_state == ST_IDLE) begin
         w_cur_mask = w_cmd_mask;
         w_cur_idx  = w_cmd_idx;
         w_cur_rpt  = w_cmd_rpt;
         w_cur_rep  = '0;
         w_cur_chip = '0;
         w_cur_gap  = '0;
         w_in_gap   = 1'b0;
         w_fire     = w_accept & w_idx_ok;
      end
   end

   // Next-state and counter advance after the current beat is produced
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_chip  = r_chip;
      w_nxt_gap   = r_gap;
      w_nxt_rep   = r_rep;
      w_beat_last = 1'b0;
      w_rep_more  = (w_cur_rep < w_cur_rpt);
      if (w_fire) begin
         w_nxt_chip = w_cur_chip;
         w_nxt_gap  = w_cur_gap;
         w_nxt_rep  = w_cur_rep;
         if (!w_in_gap && (w_cur_chip != C_CHIP_LAST)) begin
            w_nxt_state = ST_CODE;
            w_nxt_chip  = w_cur_chip + 1'b1;
         end else if (!w_in_gap && (GAP_BEATS > 0)) begin
            w_nxt_state = ST_GAP;
            w_nxt_gap   = '0;
         end else if (w_in_gap && (w_cur_gap != C_GAP_LAST)) begin
            w_nxt_state = ST_GAP;
            w_nxt_gap   = w_cur_gap + 1'b1;
         end else if (w_rep_more) begin
            w_nxt_state = ST_CODE;
            w_nxt_chip  = '0;
            w_nxt_rep   = w_cur_rep + 1'b1;
         end else begin
            w_nxt_state = ST_IDLE;
            w_beat_last = 1'b1;
         end
      end
   end

   // Select the active code; chips are sent MSB first
   always_comb begin
      w_code = '0;
      w_code[CORR_LENGTH-1:0] = CORRELATORS[0 +: CORR_LENGTH];
      for (int n = 0; n < NUM_CORRS; n++) begin
         if (w_cur_idx == CW'(n))
            w_code[CORR_LENGTH-1:0] = CORRELATORS[n*CORR_LENGTH +: CORR_LENGTH];
      end
   end

   assign w_chip_bit = w_code[C_CHIP_LAST - w_cur_chip];
   assign w_sample   = w_chip_bit ? C_POS : C_NEG;

   for (genvar n = 0; n < NUM_PARALLEL; n++) begin : g_lane
      assign w_beat_data[n*WAVE_WIDTH +: WAVE_WIDTH] =
         (w_cur_mask[n] && !w_in_gap) ? w_sample : '0;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nxt_state;
   end

   // Command latch and chip/gap/repeat counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask <= '0;
         r_idx  <= '0;
         r_rpt  <= '0;
         r_chip <= '0;
         r_gap  <= '0;
         r_rep  <= '0;
      end else begin
         if (w_accept) begin
            r_mask <= w_cmd_mask;
            r_idx  <= w_cmd_idx;
            r_rpt  <= w_cmd_rpt;
         end
         r_chip <= w_nxt_chip;
         r_gap  <= w_nxt_gap;
         r_rep  <= w_nxt_rep;
      end
   end

   // Output register; holds while the downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_dest  <= '0;
      end else if (w_adv) begin
         r_valid <= w_fire;
         r_last  <= w_fire & w_beat_last;
         if (w_fire) begin
            r_data <= w_beat_data;
            r_dest <= NUM_CORRS'(w_cur_idx);
         end
      end
   end

   assign m_axis_tvalid = r_valid;
   assign m_axis_tdata  = r_data;
   assign m_axis_tlast  = r_last;
   assign m_axis_tdest  = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_axis_bit_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_axis_bit_gen
// Brief   : Directed self-checking bench for axis_bit_gen (two configurations:
//           no gap / two codes, and one gap beat / three codes).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_axis_bit_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        m_tready;
   logic        sel;
   logic        a_svalid, a_sready, a_mvalid, a_mlast;
   logic [10:0] a_sdata;
   logic [11:0] a_mdata;
   logic [1:0]  a_mdest;
   logic        b_svalid, b_sready, b_mvalid, b_mlast;
   logic [11:0] b_sdata;
   logic [11:0] b_mdata;
   logic [2:0]  b_mdest;

   logic        obs_valid, obs_last, obs_sready;
   logic [11:0] obs_data;
   logic [2:0]  obs_dest;

   logic [5:0]  e_l0 [0:15];
   logic [5:0]  e_l1 [0:15];

   int n_checks = 0;
   int n_errors = 0;

   axis_bit_gen #(
      .NUM_PARALLEL(2), .WAVE_WIDTH(6), .AMPLITUDE(31), .NUM_CORRS(2),
      .CORR_LENGTH(4), .CORRELATORS(8'b1011_0110), .GAP_BEATS(0), .REPEAT_WIDTH(8)
   ) dut_a (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready), .s_axis_tdata(a_sdata),
      .m_axis_tvalid(a_mvalid), .m_axis_tready(m_tready), .m_axis_tdata(a_mdata),
      .m_axis_tlast(a_mlast), .m_axis_tdest(a_mdest)
   );

   axis_bit_gen #(
      .NUM_PARALLEL(2), .WAVE_WIDTH(6), .AMPLITUDE(31), .NUM_CORRS(3),
      .CORR_LENGTH(4), .CORRELATORS(12'b1100_1011_0110), .GAP_BEATS(1), .REPEAT_WIDTH(8)
   ) dut_b (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready), .s_axis_tdata(b_sdata),
      .m_axis_tvalid(b_mvalid), .m_axis_tready(m_tready), .m_axis_tdata(b_mdata),
      .m_axis_tlast(b_mlast), .m_axis_tdest(b_mdest)
   );

   assign obs_valid  = sel ? b_mvalid : a_mvalid;
   assign obs_last   = sel ? b_mlast  : a_mlast;
   assign obs_sready = sel ? b_sready : a_sready;
   assign obs_data   = sel ? b_mdata  : a_mdata;
   assign obs_dest   = sel ? b_mdest  : {1'b0, a_mdest};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pat(input int i, input logic [5:0] l0, input logic [5:0] l1);
      e_l0[i] = l0;
      e_l1[i] = l1;
   endtask

   // Present one command at a negedge; returns at the next negedge
   task automatic send(input logic s, input logic [11:0] cmd);
      sel = s;
      if (s) begin
         b_svalid = 1'b1;
         b_sdata  = cmd;
      end else begin
         a_svalid = 1'b1;
         a_sdata  = cmd[10:0];
      end
      chk("cmd_ready", {31'd0, obs_sready}, 32'd1);
      @(negedge clk);
      a_svalid = 1'b0;
      b_svalid = 1'b0;
   endtask

   // Consume and check nbeats beats against the per-repetition pattern
   task automatic collect(input int nbeats, input int plen, input logic [2:0] edest, input logic stall);
      int  k   = 0;
      int  cyc = 0;
      logic rdy;
      while (k < nbeats && cyc < 400) begin
         rdy = stall ? ((cyc % 3) == 0) : 1'b1;
         m_tready = rdy;
         chk("beat_valid", {31'd0, obs_valid}, 32'd1);
         chk("lane0", {26'd0, obs_data[5:0]}, {26'd0, e_l0[k % plen]});
         chk("lane1", {26'd0, obs_data[11:6]}, {26'd0, e_l1[k % plen]});
         chk("tdest", {29'd0, obs_dest}, {29'd0, edest});
         chk("tlast", {31'd0, obs_last}, {31'd0, (k == nbeats - 1)});
         chk("cmd_ready_busy", {31'd0, obs_sready}, 32'd0);
         if (rdy) k++;
         cyc++;
         @(negedge clk);
      end
      if (k < nbeats) chk("beat_timeout", k, nbeats);
      m_tready = 1'b1;
      chk("done_valid", {31'd0, obs_valid}, 32'd0);
      chk("done_ready", {31'd0, obs_sready}, 32'd1);
   endtask

   task automatic pat_code1_both();
      set_pat(0, 6'h1F, 6'h1F);
      set_pat(1, 6'h21, 6'h21);
      set_pat(2, 6'h1F, 6'h1F);
      set_pat(3, 6'h1F, 6'h1F);
   endtask

   initial begin
      rst      = 1'b1;
      m_tready = 1'b1;
      sel      = 1'b0;
      a_svalid = 1'b0;
      a_sdata  = '0;
      b_svalid = 1'b0;
      b_sdata  = '0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_valid", {31'd0, a_mvalid}, 32'd0);
      chk("rst_data",  {20'd0, a_mdata}, 32'd0);
      chk("rst_last",  {31'd0, a_mlast}, 32'd0);
      chk("rst_dest",  {30'd0, a_mdest}, 32'd0);
      chk("rst_ready_a", {31'd0, a_sready}, 32'd0);
      chk("rst_ready_b", {31'd0, b_sready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, a_sready}, 32'd1);

      // Code 1, both lanes, single repetition
      pat_code1_both();
      send(1'b0, {1'b0, 8'd0, 1'b1, 2'b11});
      collect(4, 4, 3'd1, 1'b0);

      // Same command under backpressure
      send(1'b0, {1'b0, 8'd0, 1'b1, 2'b11});
      collect(4, 4, 3'd1, 1'b1);

      // Out-of-range index is swallowed
      send(1'b1, {8'd5, 2'd3, 2'b11});
      chk("bad_idx_valid", {31'd0, b_mvalid}, 32'd0);
      chk("bad_idx_ready", {31'd0, b_sready}, 32'd1);
      @(negedge clk);
      chk("bad_idx_valid2", {31'd0, b_mvalid}, 32'd0);

      // Gap config: code 0 on lane 0, three repetitions
      set_pat(0, 6'h21, 6'h00);
      set_pat(1, 6'h1F, 6'h00);
      set_pat(2, 6'h1F, 6'h00);
      set_pat(3, 6'h21, 6'h00);
      set_pat(4, 6'h00, 6'h00);
      send(1'b1, {8'd2, 2'd0, 2'b01});
      collect(15, 5, 3'd0, 1'b0);

      // Gap config: code 2 on lane 1, stalled, tlast on the gap beat
      set_pat(0, 6'h00, 6'h1F);
      set_pat(1, 6'h00, 6'h1F);
      set_pat(2, 6'h00, 6'h21);
      set_pat(3, 6'h00, 6'h21);
      set_pat(4, 6'h00, 6'h00);
      send(1'b1, {8'd0, 2'd2, 2'b10});
      collect(5, 5, 3'd2, 1'b1);

      // Reset during beat 2 of a long command
      send(1'b0, {1'b0, 8'd5, 1'b0, 2'b11});
      chk("abort_beat1_valid", {31'd0, a_mvalid}, 32'd1);
      chk("abort_beat1_lane0", {26'd0, a_mdata[5:0]}, 32'h21);
      @(negedge clk);
      chk("abort_beat2_valid", {31'd0, a_mvalid}, 32'd1);
      chk("abort_beat2_lane0", {26'd0, a_mdata[5:0]}, 32'h1F);
      rst = 1'b1;
      #1;
      chk("abort_valid", {31'd0, a_mvalid}, 32'd0);
      chk("abort_last",  {31'd0, a_mlast}, 32'd0);
      chk("abort_data",  {20'd0, a_mdata}, 32'd0);
      chk("abort_ready", {31'd0, a_sready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_abort_ready", {31'd0, a_sready}, 32'd1);
      chk("post_abort_valid", {31'd0, a_mvalid}, 32'd0);

      // Normal operation resumes after the abort
      pat_code1_both();
      send(1'b0, {1'b0, 8'd0, 1'b1, 2'b11});
      collect(4, 4, 3'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
